// File: rtl/vga_scan_driver.sv
// rtl/vga_scan_driver.sv - raster scan counters, sync/colour pipeline and per-frame register snapshot
module vga_scan_driver #(
  parameter int         H_VISIBLE = 800,
  parameter int         H_FRONT   = 56,
  parameter int         H_SYNC    = 120,
  parameter int         H_BACK    = 64,
  parameter int         V_VISIBLE = 600,
  parameter int         V_FRONT   = 37,
  parameter int         V_SYNC    = 6,
  parameter int         V_BACK    = 23,
  parameter bit         SYNC_POL  = 1'b1,
  parameter int         PIX_DIV   = 1,
  parameter logic [8:0] FG_COLOR  = 9'h1FF,
  parameter logic [8:0] BG_COLOR  = 9'h000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [175:0] registers_in,
  input  logic         hit,
  output logic [10:0]  x,
  output logic [10:0]  y,
  output logic [175:0] registers,
  output logic         hsync,
  output logic         vsync,
  output logic [2:0]   red,
  output logic [2:0]   green,
  output logic [2:0]   blue,
  output logic         frame_pulse
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [10:0] X_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] X_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] Y_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] Y_SNAP = 11'(V_VISIBLE - 1);
  localparam logic [10:0] HS_ON  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_OFF = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_ON  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_OFF = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [8:0]       rgb;
  logic             tick;
  logic             visible;
  logic             in_hs;
  logic             in_vs;
  logic             snap;

  assign tick    = (div == DIV_LAST);
  assign visible = (x < X_VIS) && (y < Y_VIS);
  assign in_hs   = (x >= HS_ON) && (x < HS_OFF);
  assign in_vs   = (y >= VS_ON) && (y < VS_OFF);
  // Snapshot at the very end of the last visible line so renderers see one heap per frame.
  assign snap    = (x == X_LAST) && (y == Y_SNAP);

  assign {red, green, blue} = rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      x           <= '0;
      y           <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      rgb         <= '0;
      registers   <= '0;
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= 1'b0;
      if (tick) begin
        div <= '0;
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? 11'd0 : y + 11'd1;
        end else begin
          x <= x + 11'd1;
        end
        rgb   <= visible ? (hit ? FG_COLOR : BG_COLOR) : 9'h000;
        hsync <= in_hs ? SYNC_POL : ~SYNC_POL;
        vsync <= in_vs ? SYNC_POL : ~SYNC_POL;
        if (snap) begin
          registers   <= registers_in;
          frame_pulse <= 1'b1;
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_driver.sv
// tb/tb_vga_scan_driver.sv - scoreboard bench for vga_scan_driver on a shrunken raster
module tb_vga_scan_driver;

  localparam int HV = 16, HF = 2, HS = 3, HB = 2;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam logic [8:0] FG = 9'h1C0;
  localparam logic [8:0] BG = 9'h007;
  localparam logic [175:0] VAL1 = 176'hABCD << 160;
  localparam logic [175:0] VAL2 = 176'h1234_5678_9ABC;

  typedef struct packed {
    logic [8:0]   rgb;
    logic         hs;
    logic         vs;
    logic         fp;
    logic [175:0] regs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  logic hit_a = 1'b0;
  logic hit_b = 1'b0;
  logic [175:0] regs_in = '0;

  logic [10:0]  xa, ya, xb, yb;
  logic [175:0] regs_a, regs_b;
  logic         hsa, vsa, fpa, hsb, vsb, fpb;
  logic [2:0]   ra, ga, ba, rb, gb, bb;

  exp_t q[$];
  int nvec = 0;
  int nerr = 0;
  int mx = 0, my = 0, frame_no = 0;
  logic [175:0] mregs = '0;
  int fp_cnt = 0, hs_cnt = 0, vs_cnt = 0;

  always #5 clk = ~clk;

  vga_scan_driver #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b1), .PIX_DIV(1), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut_a (
    .clk(clk), .rst(rst), .registers_in(regs_in), .hit(hit_a),
    .x(xa), .y(ya), .registers(regs_a), .hsync(hsa), .vsync(vsa),
    .red(ra), .green(ga), .blue(ba), .frame_pulse(fpa)
  );

  vga_scan_driver #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b1), .PIX_DIV(2), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut_b (
    .clk(clk), .rst(rst_b), .registers_in(regs_in), .hit(hit_b),
    .x(xb), .y(yb), .registers(regs_b), .hsync(hsb), .vsync(vsb),
    .red(rb), .green(gb), .blue(bb), .frame_pulse(fpb)
  );

  task automatic chk(input string tag, input logic [175:0] obs, input logic [175:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"}, 176'(xa), 176'(0));
    chk({tag, "_y"}, 176'(ya), 176'(0));
    chk({tag, "_hsync"}, 176'(hsa), 176'(0));
    chk({tag, "_vsync"}, 176'(vsa), 176'(0));
    chk({tag, "_rgb"}, 176'({ra, ga, ba}), 176'(0));
    chk({tag, "_regs"}, regs_a, 176'(0));
    chk({tag, "_fp"}, 176'(fpa), 176'(0));
  endtask

  // Drive hit/registers_in for the model's current pixel, queue what the DUT must show
  // one tick later, then observe on the falling edge.
  task automatic step();
    exp_t n, e;
    logic h;
    if (frame_no == 0 && my == 4) regs_in = VAL1;
    if (frame_no == 1 && my == 1) regs_in = VAL2;
    h = (mx == 5 && my == 3) || (mx >= HV);
    hit_a = h;
    n.rgb = (mx < HV && my < VV) ? (h ? FG : BG) : 9'h000;
    n.hs  = (mx >= HV + HF) && (mx < HV + HF + HS);
    n.vs  = (my >= VV + VF) && (my < VV + VF + VS);
    n.fp  = (mx == HT - 1) && (my == VV - 1);
    if (n.fp) mregs = regs_in;
    n.regs = mregs;
    q.push_back(n);
    if (mx == HT - 1) begin
      mx = 0;
      if (my == VT - 1) begin
        my = 0;
        frame_no++;
      end else begin
        my++;
      end
    end else begin
      mx++;
    end
    @(negedge clk);
    chk("x", 176'(xa), 176'(mx));
    chk("y", 176'(ya), 176'(my));
    e = q.pop_front();
    chk("rgb", 176'({ra, ga, ba}), 176'(e.rgb));
    chk("hsync", 176'(hsa), 176'(e.hs));
    chk("vsync", 176'(vsa), 176'(e.vs));
    chk("frame_pulse", 176'(fpa), 176'(e.fp));
    chk("registers", regs_a, e.regs);
    if (fpa) fp_cnt++;
    if (hsa) hs_cnt++;
    if (vsa) vs_cnt++;
  endtask

  initial begin
    int first_k;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset_state("reset_hold");
    end
    rst = 1'b0;

    for (int i = 0; i < 5; i++) step();
    chk("x_after_5", 176'(xa), 176'(5));

    for (int i = 5; i < 2 * HT * VT; i++) step();
    chk("frame_pulse_count", 176'(fp_cnt), 176'(2));
    chk("hsync_ticks", 176'(hs_cnt), 176'(2 * VT * HS));
    chk("vsync_ticks", 176'(vs_cnt), 176'(2 * VS * HT));

    for (int i = 0; i < 5 * HT; i++) step();
    chk("mid_y_before_reset", 176'(ya), 176'(5));
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("mid_reset");
    rst = 1'b0;
    q.delete();
    mx = 0;
    my = 0;
    mregs = '0;
    fp_cnt = 0;
    for (int i = 0; i < HT * VV - 1; i++) step();
    chk("no_pulse_before_snap", 176'(fp_cnt), 176'(0));
    for (int i = 0; i < 20; i++) step();
    chk("pulse_after_snap", 176'(fp_cnt), 176'(1));

    @(negedge clk);
    rst_b = 1'b0;
    first_k = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      chk("div2_x", 176'(xb), 176'((k / 2) % HT));
      chk("div2_y", 176'(yb), 176'((k / 2) / HT));
      if (yb == 11'd1 && first_k < 0) first_k = k;
    end
    chk("div2_line_period", 176'(first_k), 176'(2 * HT));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vga_scan_driver.md
Name: vga_scan_driver

Overview:
- Drives the display-side end of the renderer interface.
- Generates the raster scan coordinates (x, y) that all renderers consume, and samples their wired-OR hit to produce pixel colour.
- Generates hsync/vsync and latches a tear-free per-frame snapshot of the 176-bit register heap bus fed to the renderers.
- Sits between the CPU register file and the renderer tree on one side, and the VGA connector on the other.

Parameters:
- H_VISIBLE, 800, visible pixels per line
- H_FRONT, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync width (pixels)
- H_BACK, 64, horizontal back porch (pixels)
- V_VISIBLE, 600, visible lines per frame
- V_FRONT, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BACK, 23, vertical back porch (lines)
- SYNC_POL, 1, active level of hsync/vsync
- PIX_DIV, 1, clocks per pixel (≥1)
- FG_COLOR, 9'h1FF, {r3,g3,b3} colour when hit
- BG_COLOR, 9'h000, {r3,g3,b3} colour in visible area when not hit

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- registers_in  in  176  live register heap (r0 in [175:160] … r10 in [15:0])
- hit  in  1  wired-OR renderer result for current (x, y), combinational from x/y
- x  out  11  current pixel column (registered)
- y  out  11  current pixel row (registered)
- registers  out  176  frame-stable snapshot to renderers
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- red  out  3  pixel red
- green  out  3  pixel green
- blue  out  3  pixel blue
- frame_pulse  out  1  one-clock strobe at snapshot instant

Behaviour:
- Pixel tick:
  - Divider counter 0..PIX_DIV-1; tick when it equals PIX_DIV-1.
  - With PIX_DIV=1, tick every clock.
  - All counter, sync, colour and snapshot updates occur only on tick clocks.
- Counters:
  - H_TOTAL = sum of H params (1040); V_TOTAL = sum of V params (666).
  - x increments 0..H_TOTAL-1, then wraps to 0 and increments y.
  - y wraps from V_TOTAL-1 to 0.
  - x and y are the counter registers, so they are ≤ 1039 and ≤ 665, which fits 11 bits.
- Visible region: visible = x < H_VISIBLE && y < V_VISIBLE.
- Pipeline (one-tick latency):
  - On each tick, the outputs are registered from the current x, y and hit:
    - red/green/blue = visible ? (hit ? FG_COLOR : BG_COLOR) : 0
    - hsync active when H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC
    - vsync active when V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC
  - Colour and syncs are therefore aligned with each other, one tick behind x/y.
  - hit is sampled in the same clock that x/y present, and must settle within one clock.
- Snapshot:
  - On the tick where x == H_TOTAL-1 and y == V_VISIBLE-1 (end of last visible line), registers <= registers_in and frame_pulse = 1 for exactly one clock.
  - registers never changes during the visible region.
  - Changes on registers_in at any other time have no effect until the next snapshot.
- Reset (synchronous, overrides tick):
  - x=0, y=0, divider=0.
  - hsync = vsync = !SYNC_POL.
  - red/green/blue = 0.
  - registers = 0.
  - frame_pulse = 0.
- Reset mid-frame restarts the scan at (0,0) on the first clock after rst deasserts. No partial snapshot is taken.
- Counter wrap at (H_TOTAL-1, V_TOTAL-1) goes to (0,0) in a single tick with no glitch pulse on the syncs.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 3 clocks, PIX_DIV=1, SYNC_POL=1.
  - Required response: x=0, y=0, hsync=0, vsync=0, rgb=0, registers=0 while reset is held.
  - After release, x reaches 5 at the 5th clock.
- Line timing:
  - Stimulus: run 2 lines.
  - Required response: hsync rises on the tick after x=856 and stays high 120 ticks.
  - x wraps 1039→0 with y 0→1; line period is 1040 clocks.
- Frame timing:
  - Stimulus: run 1 full frame.
  - Required response: vsync high for lines 637..642 (6×1040 clocks, offset one tick); frame period is 692640 clocks.
  - A second frame repeats identically.
- Colour:
  - Stimulus: drive hit=1 only when x==100 && y==50; FG=9'h1C0, BG=9'h007.
  - Required response: rgb={7,0,0} on the tick after x=100,y=50, and {0,0,7} on the neighbouring visible ticks.
  - rgb=0 at x≥800 even with hit forced 1.
- Snapshot:
  - Stimulus: change registers_in from 0 to 176'hABCD<<160 at y=300.
  - Required response: registers stays 0 until the tick at x=1039,y=599, when registers updates and frame_pulse=1 for exactly one clock.
  - A registers_in change at y=10 is not visible until the next y=599 end of line.
- Divider and mid-frame reset:
  - Stimulus: PIX_DIV=2.
  - Required response: x advances every 2nd clock and line period is 2080 clocks.
  - Stimulus: assert rst at y=400 for 1 clock.
  - Required response: scan restarts at (0,0); registers=0; no frame_pulse before the next y=599 end of line.
